spawn_rand: RTL and testbench
=============================

Name: spawn_rand

Overview:
- Downstream consumer of the game's LFSR random-bit stage.
- On request, draws bits from the LFSR and assembles a candidate asteroid spawn (x, y, heading).
- Rejects off-screen candidates and candidates inside a safe box around the ship. Retries up to a bound, then falls back to a deterministic corner.
- Hands the result to the asteroid object table over a valid/ready handshake, and owns the LFSR's en/init controls.

Parameters:
- LFSR_W, 10, width of the LFSR state bus from the LFSR stage.
- X_W, 10, spawn x width.
- Y_W, 9, spawn y width.
- X_MAX, 639, largest legal x.
- Y_MAX, 479, largest legal y.
- SAFE_R, 64, half-size of the exclusion box around the ship.
- MAX_TRIES, 15, maximum draws per request (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- seed_init  in  1  reseed/abort pulse from game control.
- lfsr_init  out  1  LFSR init; combinational copy of seed_init.
- lfsr_en  out  1  LFSR advance enable.
- lfsr_q  in  LFSR_W  LFSR state; only bit 0 is consumed.
- req  in  1  spawn request (level or pulse).
- ship_x  in  X_W  ship x position; sampled at request accept.
- ship_y  in  Y_W  ship y position; sampled at request accept.
- busy  out  1  high in any state other than IDLE.
- spawn_valid  out  1  result valid.
- spawn_ready  in  1  consumer ready.
- spawn_x  out  X_W  spawn x.
- spawn_y  out  Y_W  spawn y.
- spawn_dir  out  3  heading, 0..7.
- spawn_fallback  out  1  result came from the fallback path.

Behaviour:
- Reset (reset_n=0, async): state=IDLE. lfsr_en=0, busy=0, spawn_valid=0, spawn_fallback=0. spawn_x, spawn_y, spawn_dir=0. Try count=0, bit count=0.

States:
- IDLE:
  - req=1 accepts the request: latch ship_x/ship_y, clear try count, go to GATHER.
  - req in any other state is ignored.
- GATHER:
  - lfsr_en=1 every cycle; lfsr_en is 0 in all other states.
  - On each edge with lfsr_en=1, shift the pre-advance lfsr_q[0] into a (X_W+Y_W+3)-bit accumulator at the LSB. Bits are consumed MSB first.
  - After 22 bits (defaults): candidate x = first X_W bits, y = next Y_W bits, dir = last 3 bits. Go to CHECK.
- CHECK (1 cycle):
  - reject = (x > X_MAX) or (y > Y_MAX) or (|x - ship_x| < SAFE_R and |y - ship_y| < SAFE_R).
  - Compute the absolute differences at X_W+1 / Y_W+1 bits, with no wrap-around.
  - No reject: load outputs, spawn_fallback=0, go to OUT.
  - Reject and try count < MAX_TRIES-1: increment try count, clear bit count, go to GATHER.
  - Reject and try count = MAX_TRIES-1: go to OUT with fallback values:
    - spawn_x = (ship_x < X_MAX/2) ? X_MAX : 0
    - spawn_y = (ship_y < Y_MAX/2) ? Y_MAX : 0
    - spawn_dir = dir of the last draw
    - spawn_fallback=1
- OUT:
  - spawn_valid=1; outputs held stable until spawn_valid & spawn_ready.
  - On that edge: spawn_valid=0, go to IDLE.
  - spawn_ready is ignored outside OUT.
  - A req still high on the IDLE cycle after OUT starts a new request (no combinational IDLE bypass).

Latency:
- spawn_valid rises 23 edges after the accept edge on a first-try success.
- Each retry adds 23 edges; worst case is 23*MAX_TRIES.

seed_init:
- seed_init=1 in any state: next state IDLE, spawn_valid=0, any in-flight request is dropped, lfsr_en=0 that cycle.
- lfsr_init mirrors seed_init combinationally.
- seed_init and req in the same cycle: seed_init wins; req is not accepted.

Other rules:
- ship_x/ship_y changing mid-request has no effect; the latched copy is used.
- spawn_* outputs retain their last values after the handshake.

Test Plan:
- Reset: assert reset_n=0 mid-GATHER with no clock edge. Required: spawn_valid=0, busy=0, lfsr_en=0 immediately; IDLE after release.
- First-try success: stub drives lfsr_q[0] with the bit stream for x=100, y=200, dir=5; ship at (400,300); spawn_ready=1. Required:
  - lfsr_en high exactly 22 cycles.
  - spawn_valid rises 23 edges after accept, with (100,200,5), spawn_fallback=0.
  - busy low the cycle after.
- Rejections then success: first draw x=700 (off-screen), second (410,290) (in safe box), third (50,50,2); ship (400,300). Required: valid at edge 69 with (50,50,2), lfsr_en high for 66 cycles total.
- Fallback: stub always supplies x=1023 with ship at (100,400), MAX_TRIES=15. Required: valid at edge 345 with spawn_x=639, spawn_y=0, spawn_fallback=1.
- Backpressure: spawn_ready=0 for 10 cycles after valid, with req held high. Required: outputs stable and no new accept while busy; handshake on the edge where ready=1; next accept on the following IDLE cycle.
- Abort: pulse seed_init 5 cycles into GATHER, together with req. Required: lfsr_init=1 that cycle, state IDLE, no spawn_valid, req not accepted.

Source files
------------

// File: rtl/spawn_rand.sv
// Asteroid spawn generator: draws LFSR bits into a candidate (x, y, heading),
// rejects off-screen or near-ship candidates, retries, then falls back to a corner.
module spawn_rand #(
  parameter int LFSR_W    = 10,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int SAFE_R    = 64,
  parameter int MAX_TRIES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seed_init,
  output logic              lfsr_init,
  output logic              lfsr_en,
  input  logic [LFSR_W-1:0] lfsr_q,
  input  logic              req,
  input  logic [X_W-1:0]    ship_x,
  input  logic [Y_W-1:0]    ship_y,
  output logic              busy,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [X_W-1:0]    spawn_x,
  output logic [Y_W-1:0]    spawn_y,
  output logic [2:0]        spawn_dir,
  output logic              spawn_fallback,
  output logic [1:0]        state_dbg
);

  // Handshake: a result transfers on a rising clk edge where spawn_valid and
  // spawn_ready are both high; spawn_* stay stable while spawn_valid waits.

  localparam int ACC_W = X_W + Y_W + 3;
  localparam int BC_W  = $clog2(ACC_W + 1);
  localparam int TC_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [X_W:0]      X_MAX_V  = X_MAX[X_W:0];
  localparam logic [Y_W:0]      Y_MAX_V  = Y_MAX[Y_W:0];
  localparam logic [X_W:0]      X_HALF_V = X_MAX_V >> 1;
  localparam logic [Y_W:0]      Y_HALF_V = Y_MAX_V >> 1;
  localparam logic [X_W:0]      SAFE_X_V = SAFE_R[X_W:0];
  localparam logic [Y_W:0]      SAFE_Y_V = SAFE_R[Y_W:0];
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(ACC_W - 1);
  localparam logic [TC_W-1:0]   TRY_LAST = TC_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_CHECK  = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [BC_W-1:0] bit_q, bit_d;
  logic [TC_W-1:0] try_q, try_d;
  logic [X_W-1:0]  shx_q, shx_d;
  logic [Y_W-1:0]  shy_q, shy_d;
  logic [X_W-1:0]  sx_q, sx_d;
  logic [Y_W-1:0]  sy_q, sy_d;
  logic [2:0]      sdir_q, sdir_d;
  logic            sfb_q, sfb_d;

  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic [2:0]     cand_dir;
  logic [X_W:0]   ext_x, ext_sx, dx;
  logic [Y_W:0]   ext_y, ext_sy, dy;
  logic           off_screen, in_safe, reject;
  logic           lfsr_unused;

  assign lfsr_unused = ^lfsr_q[LFSR_W-1:1];

  // First drawn bit lands at the accumulator MSB, so x occupies the top field.
  assign cand_x   = acc_q[ACC_W-1 -: X_W];
  assign cand_y   = acc_q[Y_W+2 -: Y_W];
  assign cand_dir = acc_q[2:0];

  assign ext_x  = {1'b0, cand_x};
  assign ext_sx = {1'b0, shx_q};
  assign ext_y  = {1'b0, cand_y};
  assign ext_sy = {1'b0, shy_q};
  assign dx     = (ext_x >= ext_sx) ? (ext_x - ext_sx) : (ext_sx - ext_x);
  assign dy     = (ext_y >= ext_sy) ? (ext_y - ext_sy) : (ext_sy - ext_y);

  assign off_screen = (ext_x > X_MAX_V) || (ext_y > Y_MAX_V);
  assign in_safe    = (dx < SAFE_X_V) && (dy < SAFE_Y_V);
  assign reject     = off_screen || in_safe;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    try_d   = try_q;
    shx_d   = shx_q;
    shy_d   = shy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sdir_d  = sdir_q;
    sfb_d   = sfb_q;
    lfsr_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          shx_d   = ship_x;
          shy_d   = ship_y;
          try_d   = '0;
          bit_d   = '0;
          state_d = S_GATHER;
        end
      end
      S_GATHER: begin
        lfsr_en = 1'b1;
        acc_d   = {acc_q[ACC_W-2:0], lfsr_q[0]};
        if (bit_q == BC_LAST) begin
          bit_d   = '0;
          state_d = S_CHECK;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (!reject) begin
          sx_d    = cand_x;
          sy_d    = cand_y;
          sdir_d  = cand_dir;
          sfb_d   = 1'b0;
          state_d = S_OUT;
        end else if (try_q != TRY_LAST) begin
          try_d   = try_q + 1'b1;
          bit_d   = '0;
          state_d = S_GATHER;
        end else begin
          // Corner on the far side of the ship from its screen half.
          sx_d    = ({1'b0, shx_q} < X_HALF_V) ? X_MAX_V[X_W-1:0] : '0;
          sy_d    = ({1'b0, shy_q} < Y_HALF_V) ? Y_MAX_V[Y_W-1:0] : '0;
          sdir_d  = cand_dir;
          sfb_d   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (spawn_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reseed aborts everything, including an accept in the same cycle.
    if (seed_init) begin
      state_d = S_IDLE;
      lfsr_en = 1'b0;
      acc_d   = acc_q;
      bit_d   = '0;
      try_d   = try_q;
      shx_d   = shx_q;
      shy_d   = shy_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      sdir_d  = sdir_q;
      sfb_d   = sfb_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      bit_q   <= '0;
      try_q   <= '0;
      shx_q   <= '0;
      shy_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sdir_q  <= '0;
      sfb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      try_q   <= try_d;
      shx_q   <= shx_d;
      shy_q   <= shy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sdir_q  <= sdir_d;
      sfb_q   <= sfb_d;
    end
  end

  assign lfsr_init      = seed_init;
  assign busy           = (state_q != S_IDLE);
  assign spawn_valid    = (state_q == S_OUT) && !seed_init;
  assign spawn_x        = sx_q;
  assign spawn_y        = sy_q;
  assign spawn_dir      = sdir_q;
  assign spawn_fallback = sfb_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_spawn_rand.sv
// Directed bench for spawn_rand: a stub LFSR feeds hand-built bit streams,
// a negedge monitor checks each result against a queue of expected spawns.
module tb_spawn_rand;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int EW  = 43;

  logic           clk = 1'b0;
  logic           reset_n, seed_init, req, spawn_ready;
  logic           lfsr_init, lfsr_en, busy, spawn_valid, spawn_fallback;
  logic [9:0]     lfsr_q;
  logic [X_W-1:0] ship_x, spawn_x;
  logic [Y_W-1:0] ship_y, spawn_y;
  logic [2:0]     spawn_dir;
  logic [1:0]     state_dbg;

  logic           stream_mem [0:1023];
  int             rd_idx = 0;
  int             wr_ptr = 0;
  int             cyc    = 0;
  int             en_cnt = 0;
  int             hs_cnt = 0;
  int             checks = 0;
  int             errors = 0;

  // Expected record: {lfsr_en cycles, latency, fallback, dir, y, x}
  logic [EW-1:0]  exp_q[$];

  always #5 clk = ~clk;

  spawn_rand dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .seed_init      (seed_init),
    .lfsr_init      (lfsr_init),
    .lfsr_en        (lfsr_en),
    .lfsr_q         (lfsr_q),
    .req            (req),
    .ship_x         (ship_x),
    .ship_y         (ship_y),
    .busy           (busy),
    .spawn_valid    (spawn_valid),
    .spawn_ready    (spawn_ready),
    .spawn_x        (spawn_x),
    .spawn_y        (spawn_y),
    .spawn_dir      (spawn_dir),
    .spawn_fallback (spawn_fallback),
    .state_dbg      (state_dbg)
  );

  // Stub LFSR: presents the next stream bit, advances on each enabled edge.
  assign lfsr_q = {9'd0, stream_mem[rd_idx]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_en) begin
      en_cnt <= en_cnt + 1;
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic load_draw(input int x, input int y, input int d);
    logic [21:0] w;
    w = {x[9:0], y[8:0], d[2:0]};
    for (int i = 21; i >= 0; i--) begin
      stream_mem[wr_ptr] = w[i];
      wr_ptr++;
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input int en, input int lat, input int fb,
                                           input int d, input int y, input int x);
    return {en[9:0], lat[9:0], fb[0], d[2:0], y[8:0], x[9:0]};
  endfunction

  task automatic drv_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int limit);
    int n;
    n = 0;
    while (hs_cnt < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    check_val("handshake_timeout", int'(hs_cnt >= target), 1);
  endtask

  // Monitor / scoreboard
  int            acc_cyc = 0;
  int            acc_en  = 0;
  logic          prev_busy  = 1'b0;
  logic          prev_valid = 1'b0;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        acc_cyc = cyc;
        acc_en  = en_cnt;
      end
      if (spawn_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got x=%0d y=%0d, expected no result", spawn_x, spawn_y);
        end else begin
          e = exp_q[0];
          if (!prev_valid) begin
            check_val("latency", cyc - acc_cyc, int'(e[32:23]));
            check_val("lfsr_en_cycles", en_cnt - acc_en, int'(e[42:33]));
          end
          check_val("spawn_x", int'(spawn_x), int'(e[9:0]));
          check_val("spawn_y", int'(spawn_y), int'(e[18:10]));
          check_val("spawn_dir", int'(spawn_dir), int'(e[21:19]));
          check_val("spawn_fallback", int'(spawn_fallback), int'(e[22]));
          if (spawn_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      prev_busy  = busy;
      prev_valid = spawn_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    seed_init   = 1'b0;
    req         = 1'b0;
    spawn_ready = 1'b1;
    ship_x      = '0;
    ship_y      = '0;
    for (int i = 0; i < 1024; i++) stream_mem[i] = 1'b0;

    // Reset values
    #12;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(spawn_valid), 0);
    check_val("rst_lfsr_en", int'(lfsr_en), 0);
    check_val("rst_fallback", int'(spawn_fallback), 0);
    check_val("rst_xyd", int'({spawn_x, spawn_y, spawn_dir}), 0);
    check_val("rst_state", int'(state_dbg), 0);
    drv_edge;
    reset_n = 1'b1;

    // First-try success
    load_draw(100, 200, 5);
    exp_q.push_back(mk_exp(22, 23, 0, 5, 200, 100));
    ship_x = 10'd400; ship_y = 9'd300;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    wait_hs(1, 100);
    @(negedge clk);
    check_val("t1_busy_after", int'(busy), 0);

    // Off-screen, then in safe box, then success; ship moves mid-request
    load_draw(700, 100, 0);
    load_draw(410, 290, 1);
    load_draw(50, 50, 2);
    exp_q.push_back(mk_exp(66, 69, 0, 2, 50, 50));
    drv_edge;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    ship_x = 10'd60; ship_y = 9'd60;
    wait_hs(2, 200);
    @(negedge clk);
    check_val("t2_busy_after", int'(busy), 0);

    // Fallback after MAX_TRIES off-screen draws
    for (int i = 0; i < 15; i++) load_draw(1023, 0, i % 8);
    exp_q.push_back(mk_exp(330, 345, 1, 6, 0, 639));
    drv_edge;
    ship_x = 10'd100; ship_y = 9'd400;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    wait_hs(3, 500);
    @(negedge clk);
    check_val("t3_busy_after", int'(busy), 0);

    // Backpressure with req held high, then re-accept
    load_draw(300, 100, 3);
    load_draw(600, 400, 7);
    exp_q.push_back(mk_exp(22, 23, 0, 3, 100, 300));
    exp_q.push_back(mk_exp(22, 23, 0, 7, 400, 600));
    drv_edge;
    ship_x = 10'd400; ship_y = 9'd300;
    spawn_ready = 1'b0;
    req = 1'b1;
    n = 0;
    while (!spawn_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_valid_seen", int'(spawn_valid), 1);
    repeat (10) begin
      @(negedge clk);
      check_val("bp_hold_state", int'(state_dbg), 3);
    end
    drv_edge;
    spawn_ready = 1'b1;
    wait_hs(4, 50);
    @(negedge clk);
    check_val("bp_idle_gap", int'(busy), 0);
    @(negedge clk);
    check_val("bp_reaccept", int'(busy), 1);
    drv_edge;
    req = 1'b0;
    wait_hs(5, 100);
    @(negedge clk);
    check_val("bp_busy_after", int'(busy), 0);

    // Abort 5 cycles into GATHER, with req in the same cycle
    drv_edge;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    repeat (5) drv_edge;
    seed_init = 1'b1;
    req = 1'b1;
    #1;
    check_val("abort_lfsr_init", int'(lfsr_init), 1);
    check_val("abort_lfsr_en", int'(lfsr_en), 0);
    drv_edge;
    seed_init = 1'b0;
    req = 1'b0;
    check_val("abort_state", int'(state_dbg), 0);
    check_val("abort_valid", int'(spawn_valid), 0);
    repeat (30) @(negedge clk);
    check_val("abort_stay_idle", int'(busy), 0);

    // Normal request after the abort
    wr_ptr = rd_idx;
    load_draw(20, 460, 4);
    exp_q.push_back(mk_exp(22, 23, 0, 4, 460, 20));
    drv_edge;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    wait_hs(6, 100);
    @(negedge clk);
    check_val("t6_busy_after", int'(busy), 0);

    // Asynchronous reset in the middle of GATHER
    drv_edge;
    req = 1'b1;
    drv_edge;
    req = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_valid", int'(spawn_valid), 0);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_lfsr_en", int'(lfsr_en), 0);
    check_val("arst_spawn_x", int'(spawn_x), 0);
    drv_edge;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("arst_idle_after", int'(state_dbg), 0);

    check_val("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
